// File: rtl/pcie_ss_rx_demux_pkg.sv
// Shared types and constants for the RX TLP completion/request demux.
// t_axis_beat is the beat view at the default bus widths.
`ifndef PCIE_SS_RX_DATA_WIDTH
`define PCIE_SS_RX_DATA_WIDTH 512
`endif
`ifndef PCIE_SS_RX_TUSER_WIDTH
`define PCIE_SS_RX_TUSER_WIDTH 10
`endif

package pcie_ss_rx_demux_pkg;

   localparam int FMT_TYPE_LSB = 24;
   localparam logic [4:0] CPL_TYPE = 5'b01010;

   typedef enum logic {SOP = 1'b0, BODY = 1'b1} t_rx_state;
   typedef enum logic {DEST_CPL = 1'b0, DEST_REQ = 1'b1} t_dest;

   typedef struct packed {
      logic [`PCIE_SS_RX_DATA_WIDTH-1:0]   tdata;
      logic [`PCIE_SS_RX_DATA_WIDTH/8-1:0] tkeep;
      logic                                tlast;
      logic [`PCIE_SS_RX_TUSER_WIDTH-1:0]  tuser;
   } t_axis_beat;

   // Cpl and CplD share type bits; fmt bits [7:5] only distinguish data/no-data.
   function automatic logic is_cpl_type(input logic [4:0] type_bits);
      return type_bits == CPL_TYPE;
   endfunction

endpackage

// File: rtl/pcie_ss_axis_skid2.sv
// Two-entry AXI-S skid buffer; the output registers are entry 0.
module pcie_ss_axis_skid2 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic [1:0]       occ;
   logic [WIDTH-1:0] ent0;
   logic [WIDTH-1:0] ent1;
   logic             push;
   logic             pop;

   assign in_ready  = (occ != 2'd2);
   assign out_valid = (occ != 2'd0);
   assign out_data  = ent0;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ <= 2'd0;
      end else if (push && !pop) begin
         occ <= occ + 2'd1;
      end else if (pop && !push) begin
         occ <= occ - 2'd1;
      end
   end

   // Payload is not reset: occupancy alone qualifies it. Push with pop only
   // happens at occupancy 1, so the new beat lands straight in entry 0.
   always_ff @(posedge clk) begin
      if (push && (occ == 2'd0 || pop)) begin
         ent0 <= in_data;
      end else if (pop) begin
         ent0 <= ent1;
      end
      if (push && !pop && occ == 2'd1) begin
         ent1 <= in_data;
      end
   end

endmodule

// File: rtl/pcie_ss_axis_rx_tlp_demux.sv
// Steers each RX TLP to the completion or request AXI-S stream, decided on its SOP beat.
//  state | meaning
//  SOP   | next accepted beat is a TLP header beat
//  BODY  | mid-packet, beats follow dest_q
module pcie_ss_axis_rx_tlp_demux
   import pcie_ss_rx_demux_pkg::*;
#(
   parameter int DATA_WIDTH  = 512,
   parameter int TUSER_WIDTH = 10,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rx_tvalid,
   output logic                    rx_tready,
   input  logic [DATA_WIDTH-1:0]   rx_tdata,
   input  logic [DATA_WIDTH/8-1:0] rx_tkeep,
   input  logic                    rx_tlast,
   input  logic [TUSER_WIDTH-1:0]  rx_tuser,
   output logic                    cpl_tvalid,
   input  logic                    cpl_tready,
   output logic [DATA_WIDTH-1:0]   cpl_tdata,
   output logic [DATA_WIDTH/8-1:0] cpl_tkeep,
   output logic                    cpl_tlast,
   output logic [TUSER_WIDTH-1:0]  cpl_tuser,
   output logic                    req_tvalid,
   input  logic                    req_tready,
   output logic [DATA_WIDTH-1:0]   req_tdata,
   output logic [DATA_WIDTH/8-1:0] req_tkeep,
   output logic                    req_tlast,
   output logic [TUSER_WIDTH-1:0]  req_tuser,
   output logic [CNT_WIDTH-1:0]    cpl_pkt_cnt,
   output logic [CNT_WIDTH-1:0]    req_pkt_cnt
);

   localparam int KEEP_WIDTH = DATA_WIDTH / 8;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   typedef struct packed {
      logic [DATA_WIDTH-1:0]  tdata;
      logic [KEEP_WIDTH-1:0]  tkeep;
      logic                   tlast;
      logic [TUSER_WIDTH-1:0] tuser;
   } t_beat;

   t_rx_state state;
   t_dest     dest_q;
   t_dest     dest_sop;
   t_dest     dest_cur;
   t_beat     rx_beat;
   t_beat     cpl_beat;
   t_beat     req_beat;
   logic      cpl_not_full;
   logic      req_not_full;
   logic      accept;

   assign rx_beat  = {rx_tdata, rx_tkeep, rx_tlast, rx_tuser};
   assign dest_sop = is_cpl_type(rx_tdata[FMT_TYPE_LSB +: 5]) ? DEST_CPL : DEST_REQ;
   assign dest_cur = (state == SOP) ? dest_sop : dest_q;

   // Only the selected output gates the input: head-of-line blocking is deliberate.
   assign rx_tready = !rst && ((dest_cur == DEST_CPL) ? cpl_not_full : req_not_full);
   assign accept    = rx_tvalid && rx_tready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= SOP;
         dest_q <= DEST_REQ;
      end else if (accept) begin
         state <= rx_tlast ? SOP : BODY;
         if (state == SOP) begin
            dest_q <= dest_sop;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cpl_pkt_cnt <= '0;
         req_pkt_cnt <= '0;
      end else if (accept && state == SOP) begin
         if (dest_sop == DEST_CPL && cpl_pkt_cnt != '1) begin
            cpl_pkt_cnt <= cpl_pkt_cnt + CNT_ONE;
         end
         if (dest_sop == DEST_REQ && req_pkt_cnt != '1) begin
            req_pkt_cnt <= req_pkt_cnt + CNT_ONE;
         end
      end
   end

   pcie_ss_axis_skid2 #(.WIDTH($bits(t_beat))) u_cpl_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (rx_tvalid && dest_cur == DEST_CPL),
      .in_ready  (cpl_not_full),
      .in_data   (rx_beat),
      .out_valid (cpl_tvalid),
      .out_ready (cpl_tready),
      .out_data  (cpl_beat)
   );

   pcie_ss_axis_skid2 #(.WIDTH($bits(t_beat))) u_req_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (rx_tvalid && dest_cur == DEST_REQ),
      .in_ready  (req_not_full),
      .in_data   (rx_beat),
      .out_valid (req_tvalid),
      .out_ready (req_tready),
      .out_data  (req_beat)
   );

   assign cpl_tdata = cpl_beat.tdata;
   assign cpl_tkeep = cpl_beat.tkeep;
   assign cpl_tlast = cpl_beat.tlast;
   assign cpl_tuser = cpl_beat.tuser;
   assign req_tdata = req_beat.tdata;
   assign req_tkeep = req_beat.tkeep;
   assign req_tlast = req_beat.tlast;
   assign req_tuser = req_beat.tuser;

endmodule
